// File: rtl/mem_read_serial_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_serial_arbiter_if
// Description : Client request, memory request/response and status bundle
//               for the memory read serial arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_read_serial_arbiter_if #(
    parameter int REQ_NUM    = 3,
    parameter int SERIAL_NUM = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 64
);
    localparam int SERIAL_WIDTH = $clog2(SERIAL_NUM);

    logic [REQ_NUM-1:0]            reqValid;
    logic [REQ_NUM*ADDR_WIDTH-1:0] reqAddr;
    logic [REQ_NUM-1:0]            reqAck;
    logic [SERIAL_WIDTH-1:0]       reqSerial;
    logic                          memReqValid;
    logic [ADDR_WIDTH-1:0]         memReqAddr;
    logic [SERIAL_WIDTH-1:0]       memReqSerial;
    logic                          memReqReady;
    logic                          memRespValid;
    logic [SERIAL_WIDTH-1:0]       memRespSerial;
    logic [LINE_WIDTH-1:0]         memRespData;
    logic [REQ_NUM-1:0]            respValid;
    logic [LINE_WIDTH-1:0]         respData;
    logic [SERIAL_WIDTH-1:0]       respSerial;
    logic [SERIAL_WIDTH:0]         outstanding;
    logic                          full;
    logic                          errUnexpectedResp;

    // Arbiter side
    modport master (
        input  reqValid, reqAddr, memReqReady, memRespValid, memRespSerial, memRespData,
        output reqAck, reqSerial, memReqValid, memReqAddr, memReqSerial,
               respValid, respData, respSerial, outstanding, full, errUnexpectedResp
    );

    // Client / memory side
    modport slave (
        output reqValid, reqAddr, memReqReady, memRespValid, memRespSerial, memRespData,
        input  reqAck, reqSerial, memReqValid, memReqAddr, memReqSerial,
               respValid, respData, respSerial, outstanding, full, errUnexpectedResp
    );
endinterface
`default_nettype wire

// File: rtl/mem_read_serial_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_serial_arbiter
// Description : Round-robin read arbiter that tags each memory read with a
//               free serial and routes responses back to the owning client.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_read_serial_arbiter #(
    parameter int REQ_NUM    = 3,
    parameter int SERIAL_NUM = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 64
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    mem_read_serial_arbiter_if.master bus
);
    localparam int SERIAL_WIDTH = $clog2(SERIAL_NUM);
    localparam int c_REQ_W      = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;

    logic [SERIAL_NUM-1:0]   r_busy;
    logic [c_REQ_W-1:0]      r_owner [SERIAL_NUM];
    logic [c_REQ_W-1:0]      r_rrPtr;
    logic                    r_lock;
    logic [c_REQ_W-1:0]      r_lockIdx;
    logic [SERIAL_WIDTH-1:0] r_lockSerial;
    logic [REQ_NUM-1:0]      r_respValid;
    logic [LINE_WIDTH-1:0]   r_respData;
    logic [SERIAL_WIDTH-1:0] r_respSerial;
    logic                    r_err;

    logic [2*REQ_NUM-1:0]    w_reqRot;
    logic [c_REQ_W:0]        w_sum;
    logic [c_REQ_W:0]        w_nextSum;
    logic [c_REQ_W-1:0]      w_rrWinner;
    logic [c_REQ_W-1:0]      w_winner;
    logic [c_REQ_W-1:0]      w_nextRr;
    logic [SERIAL_WIDTH-1:0] w_freeSerial;
    logic [SERIAL_WIDTH-1:0] w_serial;
    logic [SERIAL_WIDTH:0]   w_outstanding;
    logic                    w_full;
    logic                    w_memValid;
    logic                    w_fire;
    logic                    w_respHit;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [SERIAL_NUM-1:0]   w_allocMask;
    logic [SERIAL_NUM-1:0]   w_freeMask;

    // Rotate requests so bit 0 is the requester at rrPtr; the lowest set bit wins.
    always_comb begin
        w_reqRot   = {bus.reqValid, bus.reqValid} >> r_rrPtr;
        w_rrWinner = r_rrPtr;
        w_sum      = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (w_reqRot[i]) begin
                w_sum = {1'b0, r_rrPtr} + (c_REQ_W + 1)'(i);
                if (w_sum >= (c_REQ_W + 1)'(REQ_NUM)) begin
                    w_sum = w_sum - (c_REQ_W + 1)'(REQ_NUM);
                end
                w_rrWinner = w_sum[c_REQ_W-1:0];
            end
        end
    end

    always_comb begin
        w_freeSerial  = '0;
        w_outstanding = '0;
        for (int i = SERIAL_NUM - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_freeSerial = SERIAL_WIDTH'(i);
            end
            w_outstanding = w_outstanding + (SERIAL_WIDTH + 1)'(r_busy[i]);
        end
    end

    assign w_full     = (w_outstanding == (SERIAL_WIDTH + 1)'(SERIAL_NUM));
    assign w_winner   = r_lock ? r_lockIdx : w_rrWinner;
    assign w_serial   = r_lock ? r_lockSerial : w_freeSerial;
    assign w_memValid = (r_lock || (|bus.reqValid)) && !w_full;
    assign w_fire     = w_memValid && bus.memReqReady;
    assign w_respHit  = bus.memRespValid && r_busy[bus.memRespSerial];

    always_comb begin
        w_addr = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_winner == c_REQ_W'(i)) begin
                w_addr = bus.reqAddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        w_nextSum = {1'b0, w_winner} + (c_REQ_W + 1)'(1);
        if (w_nextSum >= (c_REQ_W + 1)'(REQ_NUM)) begin
            w_nextSum = '0;
        end
        w_nextRr = w_nextSum[c_REQ_W-1:0];
    end

    // Alloc and free never collide: alloc picks a non-busy serial, free needs a busy one.
    assign w_allocMask = w_fire ? (SERIAL_NUM'(1) << w_serial) : '0;
    assign w_freeMask  = w_respHit ? (SERIAL_NUM'(1) << bus.memRespSerial) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy       <= '0;
            for (int i = 0; i < SERIAL_NUM; i++) begin
                r_owner[i] <= '0;
            end
            r_rrPtr      <= '0;
            r_lock       <= 1'b0;
            r_lockIdx    <= '0;
            r_lockSerial <= '0;
            r_respValid  <= '0;
            r_respData   <= '0;
            r_respSerial <= '0;
            r_err        <= 1'b0;
        end else begin
            r_busy <= (r_busy | w_allocMask) & ~w_freeMask;
            if (w_fire) begin
                r_owner[w_serial] <= w_winner;
                r_rrPtr           <= w_nextRr;
                r_lock            <= 1'b0;
            end else if (w_memValid) begin
                r_lock       <= 1'b1;
                r_lockIdx    <= w_winner;
                r_lockSerial <= w_serial;
            end
            r_respValid <= w_respHit ? (REQ_NUM'(1) << r_owner[bus.memRespSerial]) : '0;
            if (w_respHit) begin
                r_respData   <= bus.memRespData;
                r_respSerial <= bus.memRespSerial;
            end
            if (bus.memRespValid && !r_busy[bus.memRespSerial]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.reqAck            = w_fire ? (REQ_NUM'(1) << w_winner) : '0;
    assign bus.reqSerial         = w_serial;
    assign bus.memReqValid       = w_memValid;
    assign bus.memReqAddr        = w_addr;
    assign bus.memReqSerial      = w_serial;
    assign bus.respValid         = r_respValid;
    assign bus.respData          = r_respData;
    assign bus.respSerial        = r_respSerial;
    assign bus.outstanding       = w_outstanding;
    assign bus.full              = w_full;
    assign bus.errUnexpectedResp = r_err;
endmodule
`default_nettype wire

// File: tb/tb_mem_read_serial_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_read_serial_arbiter
// Description : Scoreboard bench for mem_read_serial_arbiter (3 clients, 4 serials).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_read_serial_arbiter;
    localparam logic [31:0] c_A0 = 32'h0000_1000;
    localparam logic [31:0] c_A1 = 32'h0000_2040;
    localparam logic [31:0] c_A2 = 32'h0000_3080;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_read_serial_arbiter_if #(.REQ_NUM(3), .SERIAL_NUM(4), .ADDR_WIDTH(32), .LINE_WIDTH(64)) bus ();

    mem_read_serial_arbiter #(.REQ_NUM(3), .SERIAL_NUM(4), .ADDR_WIDTH(32), .LINE_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { logic [2:0] ack; logic [1:0] serial; } ackExp_t;
    typedef struct { logic [2:0] valid; logic [63:0] data; logic [1:0] serial; } respExp_t;

    ackExp_t  ackQ [$];
    respExp_t respQ[$];
    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushAck(input logic [2:0] a, input logic [1:0] s);
        ackExp_t e;
        e.ack = a; e.serial = s;
        ackQ.push_back(e);
    endtask

    task automatic memResp(input logic [2:0] v, input logic [1:0] s, input logic [63:0] d);
        respExp_t e;
        bus.memRespValid  = 1'b1;
        bus.memRespSerial = s;
        bus.memRespData   = d;
        e.valid = v; e.data = d; e.serial = s;
        respQ.push_back(e);
    endtask

    // Monitor: every presented ack/response must match the head of its queue.
    initial begin
        ackExp_t  ea;
        respExp_t er;
        forever begin
            @(negedge clk);
            if (bus.reqAck !== 3'b000) begin
                if (ackQ.size() == 0) begin
                    check("unexpected reqAck", 64'(bus.reqAck), 64'd0);
                end else begin
                    ea = ackQ.pop_front();
                    check("reqAck", 64'(bus.reqAck), 64'(ea.ack));
                    check("reqSerial", 64'(bus.reqSerial), 64'(ea.serial));
                end
            end
            if (bus.respValid !== 3'b000) begin
                if (respQ.size() == 0) begin
                    check("unexpected respValid", 64'(bus.respValid), 64'd0);
                end else begin
                    er = respQ.pop_front();
                    check("respValid", 64'(bus.respValid), 64'(er.valid));
                    check("respData", bus.respData, er.data);
                    check("respSerial", 64'(bus.respSerial), 64'(er.serial));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.reqValid      = '0;
        bus.reqAddr       = {c_A2, c_A1, c_A0};
        bus.memReqReady   = 1'b0;
        bus.memRespValid  = 1'b0;
        bus.memRespSerial = '0;
        bus.memRespData   = '0;

        // Reset and idle
        tick(); tick();
        rst = 1'b1;
        tick(); #2;
        check("idle memReqValid", 64'(bus.memReqValid), 64'd0);
        check("idle reqAck", 64'(bus.reqAck), 64'd0);
        check("idle respValid", 64'(bus.respValid), 64'd0);
        check("idle respData", bus.respData, 64'd0);
        check("idle outstanding", 64'(bus.outstanding), 64'd0);
        check("idle full", 64'(bus.full), 64'd0);
        check("idle err", 64'(bus.errUnexpectedResp), 64'd0);

        // Round-robin fill to full
        bus.reqValid = 3'b111;
        bus.memReqReady = 1'b1;
        pushAck(3'b001, 2'd0); pushAck(3'b010, 2'd1);
        pushAck(3'b100, 2'd2); pushAck(3'b001, 2'd3);
        repeat (4) tick();
        #2;
        check("rr full", 64'(bus.full), 64'd1);
        check("rr outstanding", 64'(bus.outstanding), 64'd4);
        check("rr memReqValid while full", 64'(bus.memReqValid), 64'd0);
        tick();

        // Full: free serial 2, then it is reallocated the following cycle
        bus.reqValid = 3'b010;
        memResp(3'b100, 2'd2, 64'h0000_0000_2222_2222);
        #2;
        check("full blocks memReqValid", 64'(bus.memReqValid), 64'd0);
        pushAck(3'b010, 2'd2);
        tick();
        bus.memRespValid = 1'b0;
        #2;
        check("post-free memReqValid", 64'(bus.memReqValid), 64'd1);
        check("post-free memReqSerial", 64'(bus.memReqSerial), 64'd2);
        tick();
        bus.reqValid = 3'b000;
        #2;
        check("refull", 64'(bus.full), 64'd1);

        // Drain: owners s0=r0, s1=r1, s2=r1, s3=r0
        memResp(3'b001, 2'd0, 64'h0000_0000_0000_1111); tick();
        memResp(3'b010, 2'd1, 64'h0000_0000_0000_2222); tick();
        memResp(3'b010, 2'd2, 64'h0000_0000_0000_3333); tick();
        memResp(3'b001, 2'd3, 64'h0000_0000_0000_4444); tick();
        bus.memRespValid = 1'b0;
        tick(); #2;
        check("drained outstanding", 64'(bus.outstanding), 64'd0);

        // Fresh reset so rrPtr starts at r0 for the lock case
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // Lock: r2 stalled, r0 raised meanwhile must not steal the grant
        bus.memReqReady = 1'b0;
        bus.reqValid = 3'b100;
        #2;
        check("lock c0 memReqValid", 64'(bus.memReqValid), 64'd1);
        check("lock c0 addr", 64'(bus.memReqAddr), 64'(c_A2));
        check("lock c0 serial", 64'(bus.memReqSerial), 64'd0);
        tick();
        bus.reqValid = 3'b101;
        #2;
        check("lock c1 addr", 64'(bus.memReqAddr), 64'(c_A2));
        check("lock c1 serial", 64'(bus.memReqSerial), 64'd0);
        tick(); #2;
        check("lock c2 addr", 64'(bus.memReqAddr), 64'(c_A2));
        tick();
        bus.memReqReady = 1'b1;
        pushAck(3'b100, 2'd0);
        #2;
        check("lock c3 addr", 64'(bus.memReqAddr), 64'(c_A2));
        tick();
        bus.reqValid = 3'b001;
        pushAck(3'b001, 2'd1);
        #2;
        check("after lock addr", 64'(bus.memReqAddr), 64'(c_A0));
        tick();

        // Same-cycle free of serial 0 and allocation
        bus.reqValid = 3'b010;
        pushAck(3'b010, 2'd2);
        memResp(3'b100, 2'd0, 64'h0000_0000_00C3_00C3);
        #2;
        check("simul alloc serial", 64'(bus.memReqSerial), 64'd2);
        check("simul pre outstanding", 64'(bus.outstanding), 64'd2);
        tick();
        bus.reqValid = 3'b000;
        bus.memRespValid = 1'b0;
        #2;
        check("simul post outstanding", 64'(bus.outstanding), 64'd2);
        tick();

        // Unexpected response on idle serial 3
        bus.memRespValid  = 1'b1;
        bus.memRespSerial = 2'd3;
        bus.memRespData   = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        bus.memRespValid = 1'b0;
        #2;
        check("err set", 64'(bus.errUnexpectedResp), 64'd1);
        tick(); tick(); #2;
        check("err sticky", 64'(bus.errUnexpectedResp), 64'd1);
        check("pre-reset outstanding", 64'(bus.outstanding), 64'd2);

        // Asynchronous reset between clock edges
        rst = 1'b0;
        #1;
        check("async outstanding", 64'(bus.outstanding), 64'd0);
        check("async err", 64'(bus.errUnexpectedResp), 64'd0);
        check("async respData", bus.respData, 64'd0);
        check("async respValid", 64'(bus.respValid), 64'd0);
        check("async full", 64'(bus.full), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Out-of-order return: s0 owned by r1, s1 owned by r0
        bus.reqValid = 3'b010;
        pushAck(3'b010, 2'd0);
        tick();
        bus.reqValid = 3'b001;
        pushAck(3'b001, 2'd1);
        tick();
        bus.reqValid = 3'b000;
        #2;
        check("ooo outstanding 2", 64'(bus.outstanding), 64'd2);
        memResp(3'b001, 2'd1, 64'h0000_0000_0000_00A5);
        tick();
        memResp(3'b010, 2'd0, 64'h0000_0000_0000_005A);
        #2;
        check("ooo outstanding 1", 64'(bus.outstanding), 64'd1);
        tick();
        bus.memRespValid = 1'b0;
        #2;
        check("ooo outstanding 0", 64'(bus.outstanding), 64'd0);
        tick(); tick();

        check("ack queue drained", 64'(ackQ.size()), 64'd0);
        check("resp queue drained", 64'(respQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_read_serial_arbiter.md
Name: mem_read_serial_arbiter

Overview:
- Parametrised read-request arbiter and serial allocator between the cache clients and main memory. Clients are the D-cache MSHRs and the I-cache.
- Arbitrates REQ_NUM requesters round-robin and issues one read per cycle to memory with a free serial ID.
- Tracks up to SERIAL_NUM outstanding reads and routes each response back to its owning requester by serial.
- Generalises fixed "MSHR_NUM+1 outstanding, one per client" serial sizing to arbitrary client count and depth, with several outstanding reads per client.

Parameters:
REQ_NUM, 3, number of requesters (MSHR_NUM + 1 I-cache).
SERIAL_NUM, 4, maximum outstanding reads (power of two, >=2).
ADDR_WIDTH, 32, physical address width (PHY_ADDR_WIDTH).
LINE_WIDTH, 64, line width in bits (DCACHE_LINE_BIT_WIDTH).
SERIAL_WIDTH, $clog2(SERIAL_NUM), derived; not overridden.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
reqValid  in  REQ_NUM  per-requester read request
reqAddr  in  REQ_NUM*ADDR_WIDTH  per-requester line address, requester r at [r*ADDR_WIDTH +: ADDR_WIDTH]
reqAck  out  REQ_NUM  one-hot, request accepted this cycle
reqSerial  out  SERIAL_WIDTH  serial assigned, valid with reqAck
memReqValid  out  1  read request to memory
memReqAddr  out  ADDR_WIDTH  request address
memReqSerial  out  SERIAL_WIDTH  request serial
memReqReady  in  1  memory accepts request
memRespValid  in  1  read data return
memRespSerial  in  SERIAL_WIDTH  serial of returned data
memRespData  in  LINE_WIDTH  returned line
respValid  out  REQ_NUM  one-hot, data for requester
respData  out  LINE_WIDTH  returned line, shared bus
respSerial  out  SERIAL_WIDTH  serial of returned data
outstanding  out  SERIAL_WIDTH+1  busy serial count
full  out  1  outstanding == SERIAL_NUM
errUnexpectedResp  out  1  sticky, response hit a non-busy serial

Behaviour:
- Reset (rst low, async): busy[] = 0; owner[] = 0; rrPtr = 0; lock = 0; respValid = 0; respData = 0; respSerial = 0; errUnexpectedResp = 0; outstanding = 0.
- Arbitration, when lock = 0:
  - Winner is the first r with reqValid[r] set, scanning from rrPtr upward and wrapping modulo REQ_NUM.
  - memReqValid = any reqValid && !full. memReqValid never depends on memReqReady.
- Serial choice: lowest-index serial with busy = 0, using registered busy only.
- memReqAddr and memReqSerial are driven from the winner and the chosen serial.
- Lock (keeps memory-side stability):
  - When memReqValid && !memReqReady, latch lockIdx = winner and lockSerial = chosen serial, and set lock = 1.
  - While lock = 1, winner = lockIdx and serial = lockSerial, regardless of new reqValid.
  - Requesters hold reqValid and reqAddr until acked; dropping them while locked is illegal.
- Handshake (memReqValid && memReqReady):
  - Same cycle, combinational: reqAck[winner] = 1, reqSerial = serial.
  - At the edge: busy[serial] = 1, owner[serial] = winner, rrPtr = (winner+1) mod REQ_NUM, lock = 0.
  - Ack latency is 0 cycles after ready.
- Response (memRespValid && busy[memRespSerial]):
  - Next edge: respValid[owner[memRespSerial]] = 1 for exactly one cycle, respData = memRespData, respSerial = memRespSerial, busy[memRespSerial] = 0.
  - Response-to-requester latency is 1 cycle.
- Unexpected response (memRespValid && !busy[memRespSerial]): no respValid; errUnexpectedResp set at the edge and held until reset.
- Simultaneous allocate and free in one cycle:
  - Both apply; outstanding unchanged.
  - The serial being freed is not allocatable until the next cycle.
  - The allocated serial always differs from the freed one, because allocation uses pre-edge busy.
- full: while full = 1, memReqValid = 0 and lock holds its state. A response freeing a serial lets memReqValid rise the following cycle.
- Arithmetic: outstanding = popcount(busy), width SERIAL_WIDTH+1, never exceeds SERIAL_NUM. rrPtr wraps at REQ_NUM−1 → 0.
- Multiple outstanding reads per requester are allowed. Responses may return in any order.

Test Plan:
- Reset then idle: every output 0, outstanding = 0, full = 0.
- Round-robin: reqValid = 3'b111 held, memReqReady = 1 → acks in order r0, r1, r2 on cycles 1–3, with reqSerial 0, 1, 2. Cycle 4 acks r0 with serial 3; full = 1 after the edge; no more acks.
- Lock: reqValid = 3'b100, memReqReady = 0 for 3 cycles, raise reqValid[0] on cycle 1, then ready = 1 → ack goes to r2, memReqAddr stable across all 4 cycles, r0 acked next.
- Out-of-order return: serials 0 (r1) and 1 (r0) outstanding, respond serial 1 with data 64'hA5, then serial 0 with 64'h5A → respValid = 3'b001 with 64'hA5, next cycle 3'b010 with 64'h5A; outstanding 2 → 1 → 0.
- Full plus simultaneous free/alloc: full (4 busy), respond serial 2 → next cycle memReqValid = 1 and serial 2 is allocated. In a separate case, response on serial 0 and handshake in the same cycle → the new serial is not 0 and outstanding is unchanged.
- Error and async reset: response to idle serial 3 → no respValid, errUnexpectedResp = 1 sticky. Drop rst mid-cycle with 2 outstanding → busy, outputs and err all clear immediately.
